// File: rtl/serial_parity_rx.sv
// Serial parity receiver: start, DATA_BITS data bits LSB-first, parity, stop; one bit per bit_en strobe.
// Optional PARITY_RX_ERR_CNT_EN adds a saturating 8-bit error counter on port err_cnt.
//
// state  | meaning
// IDLE   | waiting for a start bit (rx=0 on a strobe)
// DATA   | shifting in data bits, XOR-accumulating parity
// PARITY | sampling the parity bit, latching the mismatch
// STOP   | sampling the stop bit, publishing word and error flags
module serial_parity_rx #(
    parameter int DATA_BITS = 8,
    parameter bit ODD       = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
`ifdef PARITY_RX_ERR_CNT_EN
    output logic [7:0]           err_cnt,
`endif
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 acc;
    logic                 err_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            acc        <= 1'b0;
            err_p      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!rx) begin
                            state     <= DATA;
                            shift_reg <= '0;
                            bit_cnt   <= '0;
                            acc       <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    DATA: begin
                        // Right shift so the first (LSB) bit lands in bit 0 after DATA_BITS strobes.
                        shift_reg <= {rx, shift_reg[DATA_BITS-1:1]};
                        acc       <= acc ^ rx;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        err_p <= acc ^ rx ^ ODD;
                        state <= STOP;
                    end
                    STOP: begin
                        // A low stop bit is reported, never reinterpreted as a start bit.
                        data_out   <= shift_reg;
                        parity_err <= err_p;
                        frame_err  <= ~rx;
                        data_valid <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PARITY_RX_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (data_valid && (parity_err || frame_err) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
